// File: rtl/pulse_rate_meter_if.sv
// Bus bundle for pulse_rate_meter: pulse input and controls in, rate, period and status out.
// The master side drives the pulse and control inputs; the slave side is the meter.
`timescale 1ns/1ps
interface pulse_rate_meter_if #(
  parameter int CNT_W = 16
);
  logic             pulse_in;
  logic             enable;
  logic             clear_total;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic [1:0]       band;
  logic [31:0]      total_steps;
  logic [31:0]      period_cycles;
  logic             period_valid;
  logic             stalled;

  modport master (
    output pulse_in, enable, clear_total,
    input  rate, rate_valid, band, total_steps, period_cycles, period_valid, stalled
  );

  modport slave (
    input  pulse_in, enable, clear_total,
    output rate, rate_valid, band, total_steps, period_cycles, period_valid, stalled
  );
endinterface

// File: rtl/pulse_rate_meter.sv
// Step-pulse rate meter: synchronises the pulse train, counts edges per gate window,
// classifies the rate into generator bands, totals steps and measures period/stall.
`timescale 1ns/1ps
module pulse_rate_meter #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int GATE_CYCLES  = 100_000_000,
  parameter int STALL_CYCLES = 50_000_000,
  parameter int CNT_W        = 16,
  parameter int BAND0        = 32,
  parameter int BAND1        = 64,
  parameter int BAND2        = 128,
  parameter int TOL          = 2
) (
  input logic              clk,
  input logic              rst,
  pulse_rate_meter_if.slave bus
);

  // CLK_HZ only documents the clock the gate length was chosen for.
  if (CLK_HZ < 1 || GATE_CYCLES < 2 || STALL_CYCLES < 1) begin : g_bad_params
    $error("pulse_rate_meter: invalid parameters");
  end

  localparam int                GATE_W     = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [31:0]       STALL_LAST = 32'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic {S_IDLE, S_GATE} state_t;

  state_t            state;
  logic              sync1, sync2, prev;
  logic              pulse_edge;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  win_cnt, win_next;
  logic [CNT_W-1:0]  rate_q;
  logic              rate_valid_q;
  logic [1:0]        band_q;
  logic [31:0]       total_q;
  logic [31:0]       gap_cnt, period_q;
  logic              period_valid_q, seen_edge, stalled_q;

  function automatic int abs_diff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // First matching band wins, so overlapping bands resolve toward BAND0.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] r);
    int v;
    v = int'(r);
    if (abs_diff(v, BAND0) <= TOL) return 2'b00;
    if (abs_diff(v, BAND1) <= TOL) return 2'b01;
    if (abs_diff(v, BAND2) <= TOL) return 2'b10;
    return 2'b11;
  endfunction

  // NOTE: reset is synchronous here, so it lives inside the posedge-only sensitivity list
  // and every state element uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.pulse_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse_edge = sync2 & ~prev;
  assign win_next   = (win_cnt == CNT_MAX) ? CNT_MAX : win_cnt + CNT_W'(pulse_edge);

  // Gate FSM; the closing cycle folds in its own edge before the window restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      gate_cnt     <= '0;
      win_cnt      <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      band_q       <= 2'b11;
    end else begin
      rate_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            state    <= S_GATE;
            gate_cnt <= '0;
            win_cnt  <= '0;
          end
        end
        S_GATE: begin
          if (!bus.enable) begin
            state    <= S_IDLE;
            gate_cnt <= '0;
            win_cnt  <= '0;
          end else if (gate_cnt == GATE_LAST) begin
            rate_q       <= win_next;
            rate_valid_q <= 1'b1;
            band_q       <= classify(win_next);
            gate_cnt     <= '0;
            win_cnt      <= '0;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            win_cnt  <= win_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear_total) begin
      total_q <= '0;
    end else if (state == S_GATE && pulse_edge) begin
      total_q <= total_q + 32'd1;
    end
  end

  // Period and stall tracking run regardless of the gate state.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      seen_edge      <= 1'b0;
      stalled_q      <= 1'b0;
    end else if (pulse_edge) begin
      gap_cnt   <= '0;
      seen_edge <= 1'b1;
      stalled_q <= 1'b0;
      if (seen_edge) begin
        period_q       <= (gap_cnt == '1) ? '1 : gap_cnt + 32'd1;
        period_valid_q <= 1'b1;
      end
    end else begin
      if (gap_cnt != '1) gap_cnt <= gap_cnt + 32'd1;
      if (gap_cnt == STALL_LAST) stalled_q <= 1'b1;
    end
  end

  assign bus.rate          = rate_q;
  assign bus.rate_valid    = rate_valid_q;
  assign bus.band          = band_q;
  assign bus.total_steps   = total_q;
  assign bus.period_cycles = period_q;
  assign bus.period_valid  = period_valid_q;
  assign bus.stalled       = stalled_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Self-checking bench for pulse_rate_meter: driven rising edges are queued with their
// expected detection cycle and counted against each closing gate window.
`timescale 1ns/1ps
module tb_pulse_rate_meter;
  localparam int GATE  = 1000;
  localparam int STALL = 300;
  localparam int CNT_W = 16;
  localparam int B0 = 20, B1 = 40, B2 = 80, TOL = 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int   gen_period = 0;
  int   ph = 0;
  int   edge_q[$];
  int   last_edge = 0;

  pulse_rate_meter_if #(.CNT_W(CNT_W)) bus ();

  pulse_rate_meter #(
    .CLK_HZ(100_000_000), .GATE_CYCLES(GATE), .STALL_CYCLES(STALL), .CNT_W(CNT_W),
    .BAND0(B0), .BAND1(B1), .BAND2(B2), .TOL(TOL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Periodic pulse source; a rise driven after posedge N is acted on at posedge N+3.
  initial begin
    bus.pulse_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_period > 0) begin
        if (ph >= gen_period) ph = 0;
        if (ph == 0 && !bus.pulse_in) begin
          bus.pulse_in = 1'b1;
          edge_q.push_back(cyc + 3);
          last_edge = cyc + 3;
        end else if (ph == gen_period / 2) begin
          bus.pulse_in = 1'b0;
        end
        ph++;
      end else begin
        ph = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] exp_band(input int r);
    if (r >= B0 - TOL && r <= B0 + TOL) return 2'b00;
    if (r >= B1 - TOL && r <= B1 + TOL) return 2'b01;
    if (r >= B2 - TOL && r <= B2 + TOL) return 2'b10;
    return 2'b11;
  endfunction

  // Called at the negedge where rate_valid is seen: pops every edge up to the window close.
  task automatic sb_pop(output int exp_rate);
    int wend;
    int wstart;
    wend     = cyc;
    wstart   = cyc - GATE + 1;
    exp_rate = 0;
    while (edge_q.size() > 0 && edge_q[0] <= wend) begin
      if (edge_q[0] >= wstart) exp_rate++;
      void'(edge_q.pop_front());
    end
    if (exp_rate > 65535) exp_rate = 65535;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < GATE + 100; i++) begin
      @(negedge clk);
      if (bus.rate_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL strobe_timeout: got no rate_valid, expected one within %0d cycles", GATE + 100);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic enable_at(output int m);
    @(negedge clk);
    bus.enable = 1'b1;
    m = cyc + 1;
  endtask

  task automatic pulse_rise(output int e);
    bus.pulse_in = 1'b1;
    e = cyc + 3;
    edge_q.push_back(e);
    last_edge = e;
  endtask

  task automatic measure_windows(input int n, input int exp_period, input string tag);
    bit ok;
    int er;
    for (int w = 0; w < n; w++) begin
      wait_strobe(ok);
      if (ok) begin
        sb_pop(er);
        n_checks++;
        if (bus.rate !== 16'(er)) begin
          n_fail++;
          $display("FAIL %s_rate w%0d: got %0d expected %0d", tag, w, bus.rate, er);
        end
        n_checks++;
        if (bus.band !== exp_band(er)) begin
          n_fail++;
          $display("FAIL %s_band w%0d: got %b expected %b", tag, w, bus.band, exp_band(er));
        end
      end
    end
    n_checks++;
    if (bus.period_cycles !== 32'(exp_period)) begin
      n_fail++;
      $display("FAIL %s_period: got %0d expected %0d", tag, bus.period_cycles, exp_period);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (bus.rate !== '0 || bus.rate_valid !== 1'b0 || bus.band !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_rate_band: got rate=%0d valid=%b band=%b expected 0/0/11",
               tag, bus.rate, bus.rate_valid, bus.band);
    end
    n_checks++;
    if (bus.total_steps !== 32'd0) begin
      n_fail++;
      $display("FAIL %s_total: got %0d expected 0", tag, bus.total_steps);
    end
    n_checks++;
    if (bus.period_cycles !== 32'd0 || bus.period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_period: got %0d/%b expected 0/0", tag, bus.period_cycles, bus.period_valid);
    end
    n_checks++;
    if (bus.stalled !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_stalled: got %b expected 0", tag, bus.stalled);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clear_total = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  task automatic test_rate_50();
    bit ok;
    int m;
    int er;
    int exp_total;
    @(negedge clk);
    bus.clear_total = 1'b1;
    @(negedge clk);
    bus.clear_total = 1'b0;
    gen_period = 50;
    enable_at(m);
    exp_total = 0;
    for (int w = 0; w < 3; w++) begin
      wait_strobe(ok);
      if (!ok) continue;
      sb_pop(er);
      exp_total += er;
      if (w == 0) begin
        n_checks++;
        if (cyc !== m + GATE) begin
          n_fail++;
          $display("FAIL first_strobe_cycle: got %0d expected %0d", cyc, m + GATE);
        end
      end
      n_checks++;
      if (bus.rate !== 16'(er) || bus.band !== exp_band(er)) begin
        n_fail++;
        $display("FAIL p50_rate_band w%0d: got %0d/%b expected %0d/%b",
                 w, bus.rate, bus.band, er, exp_band(er));
      end
      n_checks++;
      if (bus.period_cycles !== 32'd50 || bus.period_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL p50_period w%0d: got %0d/%b expected 50/1", w, bus.period_cycles, bus.period_valid);
      end
    end
    n_checks++;
    if (bus.total_steps !== 32'(exp_total)) begin
      n_fail++;
      $display("FAIL p50_total: got %0d expected %0d", bus.total_steps, exp_total);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rate_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_width: got rate_valid=%b expected 0", bus.rate_valid);
    end
  endtask

  task automatic test_rates();
    bit ok;
    gen_period = 25;
    measure_windows(3, 25, "p25");
    gen_period = 12;
    measure_windows(3, 12, "p12");
    wait_strobe(ok);
    repeat (500) @(negedge clk);
    gen_period = 50;
    measure_windows(2, 50, "mix");
  endtask

  task automatic test_stall();
    int le;
    int e2;
    gen_period = 0;
    repeat (5) @(negedge clk);
    bus.pulse_in = 1'b0;
    le = last_edge;
    wait_cyc(le + STALL - 1);
    n_checks++;
    if (bus.stalled !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_early: got %b expected 0", bus.stalled);
    end
    @(negedge clk);
    n_checks++;
    if (bus.stalled !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_assert: got %b expected 1", bus.stalled);
    end
    repeat (20) @(negedge clk);
    pulse_rise(e2);
    wait_cyc(e2 - 1);
    n_checks++;
    if (bus.stalled !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: got %b expected 1", bus.stalled);
    end
    @(negedge clk);
    n_checks++;
    if (bus.stalled !== 1'b0 || bus.period_cycles !== 32'(e2 - le)) begin
      n_fail++;
      $display("FAIL stall_clear: got stalled=%b period=%0d expected 0/%0d",
               bus.stalled, bus.period_cycles, e2 - le);
    end
    repeat (3) @(negedge clk);
    bus.pulse_in = 1'b0;
  endtask

  task automatic test_clear_total();
    int e;
    repeat (10) @(negedge clk);
    pulse_rise(e);
    wait_cyc(e - 1);
    bus.clear_total = 1'b1;
    @(negedge clk);
    bus.clear_total = 1'b0;
    n_checks++;
    if (bus.total_steps !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_vs_edge: got %0d expected 0", bus.total_steps);
    end
    repeat (3) @(negedge clk);
    bus.pulse_in = 1'b0;
    repeat (5) @(negedge clk);
    pulse_rise(e);
    wait_cyc(e);
    n_checks++;
    if (bus.total_steps !== 32'd1) begin
      n_fail++;
      $display("FAIL total_after_clear: got %0d expected 1", bus.total_steps);
    end
    repeat (3) @(negedge clk);
    bus.pulse_in = 1'b0;
    force dut.total_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.total_q;
    @(negedge clk);
    n_checks++;
    if (bus.total_steps !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL total_preload: got %h expected ffffffff", bus.total_steps);
    end
    pulse_rise(e);
    wait_cyc(e);
    n_checks++;
    if (bus.total_steps !== 32'd0) begin
      n_fail++;
      $display("FAIL total_wrap: got %0d expected 0", bus.total_steps);
    end
    repeat (3) @(negedge clk);
    bus.pulse_in = 1'b0;
  endtask

  task automatic test_final_cycle_edge();
    bit ok;
    int m;
    int e;
    int er;
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    enable_at(m);
    wait_cyc(m + GATE - 3);
    pulse_rise(e);
    repeat (2) @(negedge clk);
    bus.pulse_in = 1'b0;
    wait_strobe(ok);
    if (ok) begin
      sb_pop(er);
      n_checks++;
      if (cyc !== m + GATE || bus.rate !== 16'(er) || bus.band !== exp_band(er)) begin
        n_fail++;
        $display("FAIL last_cycle_edge: got cyc=%0d rate=%0d band=%b expected %0d/%0d/%b",
                 cyc, bus.rate, bus.band, m + GATE, er, exp_band(er));
      end
    end
  endtask

  task automatic test_disable();
    logic [CNT_W-1:0] prev_rate;
    int strobes;
    int m;
    int er;
    bit ok;
    prev_rate = bus.rate;
    gen_period = 25;
    wait_cyc(cyc + 500);
    bus.enable = 1'b0;
    strobes = 0;
    repeat (GATE + 200) begin
      @(negedge clk);
      if (bus.rate_valid) strobes++;
    end
    n_checks++;
    if (strobes !== 0 || bus.rate !== prev_rate) begin
      n_fail++;
      $display("FAIL disable_mid: got strobes=%0d rate=%0d expected 0/%0d", strobes, bus.rate, prev_rate);
    end
    enable_at(m);
    wait_cyc(m + GATE - 1);
    bus.enable = 1'b0;
    strobes = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.rate_valid) strobes++;
    end
    n_checks++;
    if (strobes !== 0 || bus.rate !== prev_rate) begin
      n_fail++;
      $display("FAIL disable_last: got strobes=%0d rate=%0d expected 0/%0d", strobes, bus.rate, prev_rate);
    end
    enable_at(m);
    wait_strobe(ok);
    if (ok) begin
      sb_pop(er);
      n_checks++;
      if (cyc !== m + GATE || bus.rate !== 16'(er)) begin
        n_fail++;
        $display("FAIL reenable: got cyc=%0d rate=%0d expected %0d/%0d", cyc, bus.rate, m + GATE, er);
      end
    end
  endtask

  task automatic test_reset_mid();
    int strobes;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b0;
    strobes = 0;
    repeat (600) begin
      @(negedge clk);
      if (bus.rate_valid) strobes++;
    end
    n_checks++;
    if (strobes !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_strobe: got %0d strobes expected 0", strobes);
    end
    gen_period = 0;
  endtask

  initial begin
    test_reset();
    test_rate_50();
    test_rates();
    test_stall();
    test_clear_total();
    test_final_cycle_edge();
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_rate_meter.md
# pulse_rate_meter

Measures the step-pulse train produced by the variable pulse generator (modes 32/64/128 Hz and hybrid). Synchronizes and edge-detects the incoming pulse, counts rising edges over a fixed gate window to report rate in pulses per gate, and accumulates a total step count. Also measures the period between consecutive edges, classifies the rate into the generator's mode bands and flags a stalled pulse train. Sits on the receive side of the motor-drive path and feeds the seven-segment/LED status logic.

## Interface
- CLK_HZ, 100000000: system clock frequency; informational only.
- GATE_CYCLES, 100000000: gate window length in clk cycles (1 s at 100 MHz).
- STALL_CYCLES, 50000000: edge-free cycles before `stalled` asserts.
- CNT_W, 16: width of `rate`.
- BAND0 / BAND1 / BAND2, 32 / 64 / 128: band centre rates, in edges per gate.
- TOL, 2: band half-width, in edges per gate.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- pulse_in  in  1  asynchronous pulse train.
- enable  in  1  1 = measure; 0 = idle and hold results.
- clear_total  in  1  synchronous clear of `total_steps`.
- rate  out  CNT_W  rising edges counted in the last completed window.
- rate_valid  out  1  one-cycle strobe when `rate` updates.
- band  out  2  classification: 00 = BAND0, 01 = BAND1, 10 = BAND2, 11 = other.
- total_steps  out  32  running count of rising edges.
- period_cycles  out  32  clk cycles between the last two rising edges.
- period_valid  out  1  high once two edges have been seen since reset.
- stalled  out  1  no edge for STALL_CYCLES cycles.

## Operation
- Input path:
  - 2-flop synchronizer, then a third flop for edge detect.
  - `edge` = sync & ~prev, one cycle wide.
  - Edge detection runs regardless of `enable`.
- State machine IDLE / GATE:
  - Reset → IDLE.
  - IDLE → GATE when enable=1. On entry, gate counter = 0 and window count = 0.
  - GATE → IDLE when enable=0. Gate counter and window count are zeroed; outputs hold.
- GATE behaviour:
  - Gate counter runs 0..GATE_CYCLES-1.
  - Window count increments on `edge` and saturates at 2^CNT_W-1.
  - On the cycle the gate counter equals GATE_CYCLES-1:
    - `rate` is loaded with the window count plus `edge` (saturating).
    - `rate_valid` is 1 for that cycle.
    - `band` is computed from that same value.
    - Gate counter and window count restart at 0; an edge on that cycle belongs to the closing window.
- Band rule: |rate-BANDn| <= TOL selects band n. Check order is BAND0, BAND1, BAND2; first match wins. No match → 11.
- total_steps:
  - +1 per `edge` while in GATE; wraps modulo 2^32.
  - clear_total has priority: clear and edge on the same cycle → 0.
- Period and stall (count in both states):
  - Gap counter increments every cycle and saturates at 2^32-1.
  - On `edge`: if an edge was already seen, period_cycles = gap+1 and period_valid = 1. Gap resets to 0.
  - stalled = 1 when the gap counter reaches STALL_CYCLES-1 without an edge. It clears on the cycle the next `edge` is detected.
- Reset values: rate = 0, rate_valid = 0, band = 11, total_steps = 0, period_cycles = 0, period_valid = 0, stalled = 0. Internal counters, synchronizer flops, state and the first-edge flag are also cleared.
- Reset mid-window discards the partial count; no rate_valid is issued.

## Timing
- pulse_in rise → `edge` is 3 clk cycles later. total_steps and the gap/period registers update on the following edge (registered).
- Pulses narrower than 2 clk cycles are not guaranteed to be detected. Pulses from the generator are >= 390625 cycles wide.
- First rate_valid occurs GATE_CYCLES cycles after the first GATE cycle, then every GATE_CYCLES cycles while enable stays 1.
- rate, band and rate_valid update on the same clock. rate and band are stable until the next strobe.
- enable dropping on the final window cycle: the window does not complete and no strobe is issued (the IDLE transition wins).

## Test plan
- Bench parameters: GATE_CYCLES=1000, STALL_CYCLES=300, BAND0/1/2=20/40/80, TOL=1.
- Reset, enable=1, pulse period 50 cycles (25 high / 25 low) for 3 windows → each rate_valid shows rate=20, band=00, period_cycles=50, period_valid=1, total_steps=60 after third window.
- Pulse period 25 cycles → rate=40, band=01. Period 12 → rate 83 or 84, band=11. Switch to period 50 mid-window → transitional window counts the mix exactly; next window rate=20.
- Stop pulses after the last edge → stalled=1 exactly 300 cycles after the last gap reset. The next edge clears stalled and period_cycles reports the full gap.
- Drive clear_total on the same cycle as an edge → total_steps=0. The next edge gives 1. Preload total_steps near 2^32-1 via a long run or a forced value → wraps to 0.
- Edge on the final gate cycle (gate counter=999) → counted in the closing window's rate. Deassert enable at cycle 500 → no strobe, and rate keeps its previous value. Re-enable → new window starts at 0. Assert rst mid-window → all outputs return to reset values and band=11.
